// File: rtl/output_row_packer_if.sv
// Pixel-result stream from the convolution core into the row packer:
// majority sign bit with its column index and destination row address.
interface output_row_packer_if #(
  parameter int COL_W  = 4,
  parameter int ADDR_W = 12
) ();
  logic              bit_valid;
  logic              bit_data;
  logic [COL_W-1:0]  bit_col;
  logic [ADDR_W-1:0] bit_waddr;

  modport master (output bit_valid, output bit_data, output bit_col, output bit_waddr);
  modport slave  (input  bit_valid, input  bit_data, input  bit_col, input  bit_waddr);
endinterface

// File: rtl/output_row_packer.sv
// Packs per-pixel sign bits into output row words, writes each completed row to
// the output SRAM, and on end request flushes a partial row plus an end marker.
module output_row_packer #(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 12,
  parameter int              COL_W      = 4,
  parameter logic [DATA_W-1:0] END_MARKER = 16'h00FF
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              start,
  input  logic [COL_W-1:0]  last_col,
  output_row_packer_if.slave bit_if,
  input  logic              end_req,
  input  logic [ADDR_W-1:0] end_addr,
  output logic              dut_sram_write_enable,
  output logic [ADDR_W-1:0] dut_sram_write_address,
  output logic [DATA_W-1:0] dut_sram_write_data,
  output logic              packer_busy,
  output logic              pack_done,
  output logic              col_err,
  output logic [ADDR_W-1:0] rows_written
);

  typedef enum logic [2:0] {IDLE, ACCUM, FLUSH, TERM, DONE} state_t;

  state_t            state, state_d;
  logic [COL_W-1:0]  last_col_q;
  logic [DATA_W-1:0] row_buf;
  logic [ADDR_W-1:0] row_addr;
  logic              pending;
  logic [ADDR_W-1:0] end_addr_q;

  logic              bit_ok, bit_last, bit_bad, pend_after;
  logic [DATA_W-1:0] merged;
  logic              we_d, done_d, busy_d;
  logic [ADDR_W-1:0] waddr_d;
  logic [DATA_W-1:0] wdata_d;

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  function automatic logic [DATA_W-1:0] row_mask(input logic [COL_W-1:0] lc);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) m[i] = (i <= int'(lc));
    return m;
  endfunction

  function automatic logic [DATA_W-1:0] put_bit(input logic [DATA_W-1:0] row,
                                                input logic [COL_W-1:0] col,
                                                input logic b);
    logic [DATA_W-1:0] r;
    r      = row;
    r[col] = b;
    return r;
  endfunction

  // Stage p0: classify the incoming pixel against the sampled row length
  always_comb begin
    bit_ok     = (state == ACCUM) && bit_if.bit_valid && (bit_if.bit_col <= last_col_q);
    bit_bad    = (state == ACCUM) && bit_if.bit_valid && (bit_if.bit_col > last_col_q);
    bit_last   = bit_ok && (bit_if.bit_col == last_col_q);
    merged     = put_bit(row_buf, bit_if.bit_col, bit_if.bit_data);
    pend_after = bit_ok ? !bit_last : pending;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (end_req) state_d = pend_after ? FLUSH : TERM;
      FLUSH:   state_d = TERM;
      TERM:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values for the registered outputs; address/data hold unless a write is issued
  always_comb begin
    we_d    = 1'b0;
    waddr_d = dut_sram_write_address;
    wdata_d = dut_sram_write_data;
    done_d  = 1'b0;
    busy_d  = packer_busy;
    case (state)
      IDLE: if (start) busy_d = 1'b1;
      ACCUM: begin
        if (bit_last) begin
          we_d    = 1'b1;
          waddr_d = bit_if.bit_waddr;
          wdata_d = merged & row_mask(last_col_q);
        end
      end
      FLUSH: begin
        we_d    = 1'b1;
        waddr_d = row_addr;
        wdata_d = row_buf & row_mask(last_col_q);
      end
      TERM: begin
        we_d    = 1'b1;
        waddr_d = end_addr_q;
        wdata_d = END_MARKER;
      end
      DONE: begin
        done_d = 1'b1;
        busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Stage p1: row buffer, bookkeeping and registered SRAM write port
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      last_col_q             <= '0;
      row_buf                <= '0;
      row_addr               <= '0;
      pending                <= 1'b0;
      end_addr_q             <= '0;
      col_err                <= 1'b0;
      rows_written           <= '0;
      dut_sram_write_enable  <= 1'b0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      packer_busy            <= 1'b0;
      pack_done              <= 1'b0;
    end else begin
      dut_sram_write_enable  <= we_d;
      dut_sram_write_address <= waddr_d;
      dut_sram_write_data    <= wdata_d;
      packer_busy            <= busy_d;
      pack_done              <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            last_col_q   <= last_col;
            row_buf      <= '0;
            pending      <= 1'b0;
            col_err      <= 1'b0;
            rows_written <= '0;
          end
        end
        ACCUM: begin
          if (bit_bad) col_err <= 1'b1;
          if (bit_ok) begin
            row_addr <= bit_if.bit_waddr;
            if (bit_last) begin
              row_buf      <= '0;
              pending      <= 1'b0;
              rows_written <= rows_written + ONE;
            end else begin
              row_buf <= merged;
              pending <= 1'b1;
            end
          end
          if (end_req) end_addr_q <= end_addr;
        end
        FLUSH: begin
          row_buf      <= '0;
          pending      <= 1'b0;
          rows_written <= rows_written + ONE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_output_row_packer.sv
// Directed bench for output_row_packer: row packing, back-to-back rows, flush,
// end marker, column error and mid-operation reset.
module tb_output_row_packer;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        start;
  logic [3:0]  last_col;
  logic        end_req;
  logic [11:0] end_addr;
  logic        we;
  logic [11:0] waddr;
  logic [15:0] wdata;
  logic        busy, done, col_err;
  logic [11:0] rows;

  output_row_packer_if #(.COL_W(4), .ADDR_W(12)) bus ();

  output_row_packer dut (
    .clk(clk), .reset_b(reset_b), .start(start), .last_col(last_col),
    .bit_if(bus.slave), .end_req(end_req), .end_addr(end_addr),
    .dut_sram_write_enable(we), .dut_sram_write_address(waddr),
    .dut_sram_write_data(wdata), .packer_busy(busy), .pack_done(done),
    .col_err(col_err), .rows_written(rows)
  );

  always #5 clk = ~clk;

  typedef struct { logic [11:0] a; logic [15:0] d; int c; } wr_t;
  wr_t wq[$];
  int  cyc = 0;
  int  done_cycles = 0;
  logic done_busy = 1'b0;
  int  n_vec = 0;
  int  n_miss = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (we) wq.push_back('{a: waddr, d: wdata, c: cyc});
    if (done) begin
      done_cycles++;
      done_busy = busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input int idx, input logic [11:0] a, input logic [15:0] d);
    if (idx < wq.size()) begin
      chk({tag, "_addr"}, 32'(wq[idx].a), 32'(a));
      chk({tag, "_data"}, 32'(wq[idx].d), 32'(d));
    end else begin
      chk({tag, "_missing"}, 32'(wq.size()), 32'(idx + 1));
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic d,
                       input logic [11:0] a, input logic e, input logic [11:0] ea);
    @(posedge clk); #1;
    bus.bit_valid = v; bus.bit_col = c; bus.bit_data = d; bus.bit_waddr = a;
    end_req = e; end_addr = ea;
  endtask

  task automatic send_bit(input logic [3:0] c, input logic d, input logic [11:0] a);
    drive(1'b1, c, d, a, 1'b0, 12'h000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, 1'b0, 12'h000, 1'b0, 12'h000);
  endtask

  task automatic do_start(input logic [3:0] lc);
    @(posedge clk); #1;
    start = 1'b1; last_col = lc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    reset_b = 1'b0; start = 1'b0; last_col = 4'd0; end_req = 1'b0; end_addr = 12'h000;
    bus.bit_valid = 1'b0; bus.bit_data = 1'b0; bus.bit_col = 4'd0; bus.bit_waddr = 12'h000;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", 32'(we), 0);
    chk("rst_addr", 32'(waddr), 0);
    chk("rst_data", 32'(wdata), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_colerr", 32'(col_err), 0);
    chk("rst_rows", 32'(rows), 0);
    @(negedge clk); reset_b = 1'b1;

    // Session 1: alternating row, then two all-ones rows, then end with nothing pending
    do_start(4'd13);
    chk("s1_busy", 32'(busy), 1);
    for (int c = 0; c < 14; c++) send_bit(4'(c), c[0], 12'h010);
    idle(2);
    chk("t1_cnt", 32'(wq.size()), 1);
    chk_wr("t1", 0, 12'h010, 16'h2AAA);
    chk("t1_rows", 32'(rows), 1);
    idle(3);
    chk("t1_hold_we", 32'(we), 0);
    chk("t1_hold_data", 32'(wdata), 32'h2AAA);
    wq.delete();
    for (int c = 0; c < 14; c++) send_bit(4'(c), 1'b1, 12'h010);
    for (int c = 0; c < 14; c++) send_bit(4'(c), 1'b1, 12'h011);
    idle(2);
    chk("t2_cnt", 32'(wq.size()), 2);
    chk_wr("t2_r0", 0, 12'h010, 16'h3FFF);
    chk_wr("t2_r1", 1, 12'h011, 16'h3FFF);
    if (wq.size() >= 2) chk("t2_gap", 32'(wq[1].c - wq[0].c), 14);
    chk("t2_rows", 32'(rows), 3);
    wq.delete(); done_cycles = 0;
    drive(1'b0, 4'd0, 1'b0, 12'h000, 1'b1, 12'h030);
    idle(6);
    chk("t4_cnt", 32'(wq.size()), 1);
    chk_wr("t4_mark", 0, 12'h030, 16'h00FF);
    chk("t4_rows", 32'(rows), 3);
    chk("t4_done", 32'(done_cycles), 1);
    chk("t4_done_busy", 32'(done_busy), 0);
    chk("t4_busy", 32'(busy), 0);

    // Session 2: partial row flushed by end request
    wq.delete(); done_cycles = 0;
    do_start(4'd13);
    chk("s2_rows_clr", 32'(rows), 0);
    for (int c = 0; c < 5; c++) send_bit(4'(c), 1'b1, 12'h010);
    drive(1'b0, 4'd0, 1'b0, 12'h000, 1'b1, 12'h020);
    idle(6);
    chk("t3_cnt", 32'(wq.size()), 2);
    chk_wr("t3_row", 0, 12'h010, 16'h001F);
    chk_wr("t3_mark", 1, 12'h020, 16'h00FF);
    chk("t3_rows", 32'(rows), 1);
    chk("t3_done", 32'(done_cycles), 1);

    // Session 3: out-of-range column, then a valid row whose last bit meets end_req
    wq.delete(); done_cycles = 0;
    do_start(4'd5);
    send_bit(4'd9, 1'b1, 12'h040);
    idle(2);
    chk("t5_err", 32'(col_err), 1);
    chk("t5_nowr", 32'(wq.size()), 0);
    send_bit(4'd0, 1'b1, 12'h041);
    send_bit(4'd1, 1'b0, 12'h041);
    send_bit(4'd2, 1'b1, 12'h041);
    send_bit(4'd3, 1'b1, 12'h041);
    send_bit(4'd4, 1'b0, 12'h041);
    drive(1'b1, 4'd5, 1'b1, 12'h041, 1'b1, 12'h042);
    idle(6);
    chk("t5_cnt", 32'(wq.size()), 2);
    chk_wr("t5_row", 0, 12'h041, 16'h002D);
    chk_wr("t5_mark", 1, 12'h042, 16'h00FF);
    chk("t5_err_sticky", 32'(col_err), 1);
    chk("t5_rows", 32'(rows), 1);
    chk("t5_done", 32'(done_cycles), 1);

    // Session 4: single-column rows write on every valid bit
    wq.delete(); done_cycles = 0;
    do_start(4'd0);
    chk("t7_err_clr", 32'(col_err), 0);
    send_bit(4'd0, 1'b1, 12'h005);
    send_bit(4'd0, 1'b0, 12'h006);
    send_bit(4'd0, 1'b1, 12'h007);
    idle(2);
    chk("t7_cnt", 32'(wq.size()), 3);
    chk_wr("t7_w0", 0, 12'h005, 16'h0001);
    chk_wr("t7_w1", 1, 12'h006, 16'h0000);
    chk_wr("t7_w2", 2, 12'h007, 16'h0001);
    if (wq.size() >= 3) chk("t7_gap", 32'(wq[2].c - wq[0].c), 2);
    chk("t7_rows", 32'(rows), 3);
    drive(1'b0, 4'd0, 1'b0, 12'h000, 1'b1, 12'h031);
    idle(6);
    chk_wr("t7_mark", 3, 12'h031, 16'h00FF);
    chk("t7_done", 32'(done_cycles), 1);

    // Session 5: reset in the middle of a row
    wq.delete(); done_cycles = 0;
    do_start(4'd13);
    for (int c = 0; c < 7; c++) send_bit(4'(c), 1'b1, 12'h050);
    idle(1);
    #2 reset_b = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_we", 32'(we), 0);
    chk("t6_rst_data", 32'(wdata), 0);
    chk("t6_rst_addr", 32'(waddr), 0);
    @(negedge clk); reset_b = 1'b1;
    idle(2);
    chk("t6_nowr", 32'(wq.size()), 0);
    do_start(4'd13);
    for (int c = 0; c < 14; c++) send_bit(4'(c), (c >= 7), 12'h051);
    idle(2);
    chk("t6_cnt", 32'(wq.size()), 1);
    chk_wr("t6_row", 0, 12'h051, 16'h3F80);
    chk("t6_rows", 32'(rows), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
